// File: rtl/access_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : access_pkg
//  Description : Shared types and constants for the parking access keypad path.
//  Revision    : 1.0
// ============================================================================
package access_pkg;

    localparam int CODE_W = 8;

    // One-hot state encodings. The access controller imports these as well.
    localparam logic [3:0] ESPERA      = 4'b0001;
    localparam logic [3:0] UN_DIGITO   = 4'b0010;
    localparam logic [3:0] DOS_DIGITOS = 4'b0100;
    localparam logic [3:0] ENTREGA     = 4'b1000;

    typedef enum logic [3:0] {
        S_ESPERA      = ESPERA,
        S_UN_DIGITO   = UN_DIGITO,
        S_DOS_DIGITOS = DOS_DIGITOS,
        S_ENTREGA     = ENTREGA
    } estado_t;

    localparam logic [3:0] TECLA_BORRAR = 4'hA;
    localparam logic [3:0] TECLA_ENTER  = 4'hB;

    function automatic logic es_digito(input logic [3:0] t);
        return (t <= 4'd9);
    endfunction

endpackage
`default_nettype wire

// File: rtl/teclado_clave_captura_if.sv
`default_nettype none
// ============================================================================
//  Module      : teclado_clave_captura_if
//  Description : Keypad strobe and downstream code handshake bundle.
//  Revision    : 1.0
// ============================================================================
interface teclado_clave_captura_if;
    import access_pkg::*;

    logic                sensor_llegada_vehiculo;
    logic                tecla_valida;
    logic [3:0]          tecla;
    logic                clave_aceptada;
    logic [CODE_W-1:0]   clave_ingresada;
    logic                clave_valida;
    logic [1:0]          digitos_cnt;
    logic                error_tiempo;

    // The capture block sits on the slave side.
    modport slave (
        input  sensor_llegada_vehiculo, tecla_valida, tecla, clave_aceptada,
        output clave_ingresada, clave_valida, digitos_cnt, error_tiempo
    );

    modport master (
        output sensor_llegada_vehiculo, tecla_valida, tecla, clave_aceptada,
        input  clave_ingresada, clave_valida, digitos_cnt, error_tiempo
    );
endinterface
`default_nettype wire

// File: rtl/teclado_clave_captura_contador_timeout.sv
`default_nettype none
// ============================================================================
//  Module      : contador_timeout
//  Description : Inter-key idle counter; flags the last idle cycle allowed.
//  Revision    : 1.0
// ============================================================================
module contador_timeout #(
    parameter int TIMEOUT_CYCLES = 1000
) (
    input  wire logic clock,
    input  wire logic reset,
    input  wire logic clear,
    input  wire logic enable,
    output logic      expira
);
    localparam int CW = $clog2(TIMEOUT_CYCLES + 1);

    logic [CW-1:0] cuenta_q;

    always_ff @(posedge clock) begin
        if (reset || clear) begin
            cuenta_q <= '0;
        end else if (enable) begin
            cuenta_q <= cuenta_q + CW'(1);
        end
    end

    assign expira = (cuenta_q == CW'(TIMEOUT_CYCLES - 1));

endmodule
`default_nettype wire

// File: rtl/teclado_clave_captura.sv
`default_nettype none
// ============================================================================
//  Module      : teclado_clave_captura
//  Description : Two-digit BCD keypad capture with valid/accept hand-off.
//  Revision    : 1.0
// ============================================================================
module teclado_clave_captura
    import access_pkg::*;
#(
    parameter int TIMEOUT_CYCLES = 1000
) (
    input  wire logic                clock,
    input  wire logic                reset,
    teclado_clave_captura_if.slave   bus
);
    estado_t           estado_q, estado_d;
    logic [CODE_W-1:0] clave_q, clave_d;
    logic [1:0]        cnt_q, cnt_d;
    logic              error_q, error_d;
    logic              expira;
    logic              tecla_act;
    logic              en_entrada;

    assign tecla_act  = bus.tecla_valida;
    assign en_entrada = (estado_q == S_UN_DIGITO) || (estado_q == S_DOS_DIGITOS);

    // Any strobe counts as activity; the counter only runs while digits are held.
    contador_timeout #(
        .TIMEOUT_CYCLES (TIMEOUT_CYCLES)
    ) u_contador_timeout (
        .clock  (clock),
        .reset  (reset),
        .clear  (!en_entrada || tecla_act || !bus.sensor_llegada_vehiculo),
        .enable (en_entrada && !tecla_act),
        .expira (expira)
    );

    always_ff @(posedge clock) begin
        if (reset) begin
            estado_q <= S_ESPERA;
            clave_q  <= '0;
            cnt_q    <= 2'd0;
            error_q  <= 1'b0;
        end else begin
            estado_q <= estado_d;
            clave_q  <= clave_d;
            cnt_q    <= cnt_d;
            error_q  <= error_d;
        end
    end

    always_comb begin
        estado_d = estado_q;
        clave_d  = clave_q;
        cnt_d    = cnt_q;
        error_d  = 1'b0;

        if (!bus.sensor_llegada_vehiculo) begin
            estado_d = S_ESPERA;
            clave_d  = '0;
            cnt_d    = 2'd0;
        end else begin
            unique case (estado_q)
                S_ESPERA: begin
                    if (tecla_act && es_digito(bus.tecla)) begin
                        clave_d[7:4] = bus.tecla;
                        cnt_d        = 2'd1;
                        estado_d     = S_UN_DIGITO;
                    end
                end
                S_UN_DIGITO, S_DOS_DIGITOS: begin
                    if (tecla_act && bus.tecla == TECLA_BORRAR) begin
                        estado_d = S_ESPERA;
                        clave_d  = '0;
                        cnt_d    = 2'd0;
                    end else if (expira && !tecla_act) begin
                        estado_d = S_ESPERA;
                        clave_d  = '0;
                        cnt_d    = 2'd0;
                        error_d  = 1'b1;
                    end else if (tecla_act && estado_q == S_UN_DIGITO
                                 && es_digito(bus.tecla)) begin
                        clave_d[3:0] = bus.tecla;
                        cnt_d        = 2'd2;
                        estado_d     = S_DOS_DIGITOS;
                    end else if (tecla_act && estado_q == S_DOS_DIGITOS
                                 && bus.tecla == TECLA_ENTER) begin
                        estado_d = S_ENTREGA;
                    end
                end
                S_ENTREGA: begin
                    if (bus.clave_aceptada) begin
                        estado_d = S_ESPERA;
                        clave_d  = '0;
                        cnt_d    = 2'd0;
                    end
                end
                default: begin
                    estado_d = S_ESPERA;
                    clave_d  = '0;
                    cnt_d    = 2'd0;
                end
            endcase
        end
    end

    assign bus.clave_ingresada = clave_q;
    assign bus.digitos_cnt     = cnt_q;
    assign bus.clave_valida    = (estado_q == S_ENTREGA);
    assign bus.error_tiempo    = error_q;

endmodule
`default_nettype wire

// File: doc/teclado_clave_captura.md
# teclado_clave_captura

Keypad front end for the parking access controller. Collects two decimal digits from a strobed keypad while a vehicle is at the gate, packs them as two BCD nibbles, and hands the 8-bit code downstream with a valid/accept handshake. The downstream access controller consumes `clave_ingresada` and checks it against the stored PIN. The block also clears partial entries on a clear key, on an inter-key timeout, or when the vehicle leaves.

## Interface
- `TIMEOUT_CYCLES`, default 1000: number of idle cycles allowed between accepted keys before a partial entry is discarded; legal range ≥ 2.
- `clock` in 1: rising-edge clock.
- `reset` in 1: synchronous, active-high.
- `sensor_llegada_vehiculo` in 1: vehicle present at the gate; capture is enabled only while this is high.
- `tecla_valida` in 1: one-cycle strobe, `tecla` is valid this cycle.
- `tecla` in 4: key code. 0x0–0x9 = digit, 0xA = clear (borrar), 0xB = enter, 0xC–0xF = ignored.
- `clave_aceptada` in 1: downstream accept; completes a transfer when high together with `clave_valida`.
- `clave_ingresada` out 8: {first digit, second digit}; stable while `clave_valida` is high.
- `clave_valida` out 1: code ready for downstream.
- `digitos_cnt` out 2: digits currently held (0, 1 or 2), for the display.
- `error_tiempo` out 1: one-cycle pulse when a partial entry times out.

## Operation
States are one-hot.
- **ESPERA**: no digits held.
  - A digit stores into `clave_ingresada[7:4]` and moves to UN_DIGITO.
  - Enter and clear are ignored.
- **UN_DIGITO**:
  - A digit stores into `[3:0]` and moves to DOS_DIGITOS.
  - Clear returns to ESPERA.
  - Enter is ignored.
- **DOS_DIGITOS**:
  - Enter moves to ENTREGA.
  - Clear returns to ESPERA.
  - Further digits are ignored; there is no overwrite.
- **ENTREGA**:
  - `clave_valida` = 1 and all keys are ignored.
  - `clave_aceptada` = 1 returns to ESPERA.
- On every return to ESPERA, `clave_ingresada` and `digitos_cnt` clear to 0.
- If `sensor_llegada_vehiculo` = 0 in any state, the next state is ESPERA, including ENTREGA, which drops an unaccepted code. Keys are ignored while the sensor is low.
- **Timeout counter**:
  - Width is clog2(TIMEOUT_CYCLES+1).
  - It clears on entry to UN_DIGITO, on every accepted key, and in ESPERA and ENTREGA.
  - It increments each cycle in UN_DIGITO and DOS_DIGITOS with no `tecla_valida`.
  - When it equals TIMEOUT_CYCLES−1 and no key arrives, the next state is ESPERA and `error_tiempo` = 1 for the following cycle.
- Priority, highest first: `reset` > sensor low > clear > timeout > digit/enter. A key that arrives in the same cycle as the would-be timeout is processed and the timeout does not fire.
- All outputs reset to 0, and the state resets to ESPERA.

## Timing
- Key-to-register latency is 1 cycle: a digit strobed at edge N is visible on `clave_ingresada` and `digitos_cnt` after edge N.
- `clave_valida` rises on the edge that samples enter in DOS_DIGITOS.
- Handshake: a transfer completes on the edge where `clave_valida` and `clave_aceptada` are both high. `clave_valida` falls after that edge.
  - `clave_aceptada` while `clave_valida` = 0 is ignored.
  - Holding `clave_aceptada` high continuously yields a 1-cycle valid pulse per code.
- `error_tiempo` is exactly 1 cycle wide and does not coincide with `clave_valida`.
- Reset mid-entry or mid-handshake: the next cycle is ESPERA with all outputs 0 and no `error_tiempo` pulse.

## Structure
- Shared package `access_pkg` holds:
  - state localparams (ESPERA=4'b0001, UN_DIGITO=4'b0010, DOS_DIGITOS=4'b0100, ENTREGA=4'b1000);
  - key codes TECLA_BORRAR=4'hA and TECLA_ENTER=4'hB;
  - code width 8.
  - The access controller imports the same package.
- One sub-module: `contador_timeout`, parameterized by TIMEOUT_CYCLES, with inputs clear/enable and output `expira`.
- The FSM and the digit registers stay in the top module.

## Test plan
- Sensor=1, keys 4, 7, enter, `clave_aceptada` held 0 for 3 cycles then 1 → `clave_ingresada` = 8'h47, `clave_valida` high 4 cycles, then 0 with `digitos_cnt` = 0.
- Keys 4, enter, 2, 9, enter → enter after one digit ignored, 9 ignored, code 8'h42 presented.
- TIMEOUT_CYCLES=8, key 5 then idle 8 cycles → `error_tiempo` pulses once, `digitos_cnt` returns to 0. Repeating with a key on cycle 7 gives no timeout.
- Keys 3, 1, clear, 0, 6, enter → code 8'h06. A clear in ESPERA leaves no effect.
- Code pending in ENTREGA, sensor drops to 0 → `clave_valida` falls next cycle; keys while sensor=0 leave `digitos_cnt` = 0.
- Reset asserted after one digit and also during ENTREGA → all outputs 0 next cycle; the next entry works normally.
